chacha20_poly1305_bus_master: RTL and testbench

Register-bus initiator that drives a complete ChaCha20-Poly1305 operation through the core's 8-bit-address register bus wrapper. On a host `start` it latches key, nonce and data vectors, writes them word-by-word, issues the init, next and done control commands, polls status until ready (bounded), and then reads back two result words. It sits between a host/DMA controller and the `chacha20_poly1305_bus` responder, so software no longer sequences individual register accesses.

---
 rtl/chacha20_poly1305_bus_master.sv | 235 +++++++++++++++++++++++
 tb/tb_chacha20_poly1305_bus_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_poly1305_bus_master.sv
// Register-bus initiator that sequences one ChaCha20-Poly1305 operation:
// key/nonce/data writes, init/next commands, bounded status polling, completion write, two result reads.
module chacha20_poly1305_bus_master #(
    parameter int unsigned POLL_LIMIT  = 1024,
    parameter logic [7:0]  INIT_GAP    = 8'd2,
    parameter int unsigned READY_BIT   = 0,
    parameter logic [7:0]  RESULT_BASE = 8'h40
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [63:0]  data_in,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [31:0]  status_out,
    output logic [63:0]  result,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data
);
    localparam int unsigned    CW        = $clog2(POLL_LIMIT + 1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(POLL_LIMIT);
    localparam logic [CW-1:0]  CNT_MAX   = {CW{1'b1}};

    typedef enum logic [3:0] {
        IDLE, WR_KEY, WR_NONCE, WR_DATA, WR_INIT, GAP, WR_NEXT, POLL_REQ,
        POLL_WAIT, WR_DONE, RD0_REQ, RD0_WAIT, RD1_REQ, RD1_WAIT, FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [255:0]    key_q, key_d;
    logic [95:0]     nonce_q, nonce_d;
    logic [63:0]     data_q, data_d;
    logic [CW-1:0]   poll_cnt_q, poll_cnt_d, cnt_inc_s;
    logic            error_q, error_d;
    logic [31:0]     status_q, status_d;
    logic [63:0]     result_q, result_d;
    logic            cs_q, cs_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;

    function automatic logic [31:0] nonce_word(input logic [95:0] n, input logic [1:0] i);
        case (i)
            2'd0:    return n[31:0];
            2'd1:    return n[63:32];
            2'd2:    return n[95:64];
            default: return 32'h0;
        endcase
    endfunction

    assign cnt_inc_s = (poll_cnt_q == CNT_MAX) ? poll_cnt_q : poll_cnt_q + CW'(1);

    // Sequencer next state and captured data.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        key_d      = key_q;
        nonce_d    = nonce_q;
        data_d     = data_q;
        poll_cnt_d = poll_cnt_q;
        error_d    = error_q;
        status_d   = status_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d      = key;
                    nonce_d    = nonce;
                    data_d     = data_in;
                    error_d    = 1'b0;
                    poll_cnt_d = '0;
                    idx_d      = 8'd0;
                    state_d    = WR_KEY;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_KEY: begin
                if (idx_q == 8'd7) begin
                    idx_d   = 8'd0;
                    state_d = WR_NONCE;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            WR_NONCE: begin
                if (idx_q == 8'd2) begin
                    idx_d   = 8'd0;
                    state_d = WR_DATA;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            WR_DATA: begin
                if (idx_q == 8'd1) begin
                    idx_d   = 8'd0;
                    state_d = WR_INIT;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            WR_INIT: begin
                idx_d = 8'd0;
                if (INIT_GAP == 8'd0) begin
                    state_d = WR_NEXT;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (idx_q == INIT_GAP - 8'd1) begin
                    state_d = WR_NEXT;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            WR_NEXT:  state_d = POLL_REQ;
            POLL_REQ: state_d = POLL_WAIT;
            POLL_WAIT: begin
                status_d   = read_data;
                poll_cnt_d = cnt_inc_s;
                if (read_data[READY_BIT]) begin
                    state_d = WR_DONE;
                end else if (cnt_inc_s == CNT_LIMIT) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    state_d = POLL_REQ;
                end
            end
            WR_DONE:  state_d = RD0_REQ;
            RD0_REQ:  state_d = RD0_WAIT;
            RD0_WAIT: begin
                result_d[31:0] = read_data;
                state_d        = RD1_REQ;
            end
            RD1_REQ:  state_d = RD1_WAIT;
            RD1_WAIT: begin
                result_d[63:32] = read_data;
                state_d         = FINISH;
            end
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Bus outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        cs_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = (state_d != IDLE) && (state_d != FINISH);
        done_d  = (state_d == FINISH);
        case (state_d)
            WR_KEY: begin
                cs_d = 1'b1; we_d = 1'b1;
                addr_d  = 8'h10 + idx_d;
                wdata_d = key_d[{idx_d[2:0], 5'd0} +: 32];
            end
            WR_NONCE: begin
                cs_d = 1'b1; we_d = 1'b1;
                addr_d  = 8'h20 + idx_d;
                wdata_d = nonce_word(nonce_d, idx_d[1:0]);
            end
            WR_DATA: begin
                cs_d = 1'b1; we_d = 1'b1;
                addr_d  = 8'h30 + idx_d;
                wdata_d = idx_d[0] ? data_d[63:32] : data_d[31:0];
            end
            WR_INIT: begin cs_d = 1'b1; we_d = 1'b1; addr_d = 8'h08; wdata_d = 32'h1; end
            WR_NEXT: begin cs_d = 1'b1; we_d = 1'b1; addr_d = 8'h08; wdata_d = 32'h2; end
            WR_DONE: begin cs_d = 1'b1; we_d = 1'b1; addr_d = 8'h08; wdata_d = 32'h4; end
            POLL_REQ: begin cs_d = 1'b1; addr_d = 8'h09; end
            RD0_REQ:  begin cs_d = 1'b1; addr_d = RESULT_BASE; end
            RD1_REQ:  begin cs_d = 1'b1; addr_d = RESULT_BASE + 8'd1; end
            default: begin
                cs_d = 1'b0;
            end
        endcase
    end

    // State, captured data and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 8'd0;
            key_q      <= 256'd0;
            nonce_q    <= 96'd0;
            data_q     <= 64'd0;
            poll_cnt_q <= '0;
            error_q    <= 1'b0;
            status_q   <= 32'd0;
            result_q   <= 64'd0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 8'd0;
            wdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            key_q      <= key_d;
            nonce_q    <= nonce_d;
            data_q     <= data_d;
            poll_cnt_q <= poll_cnt_d;
            error_q    <= error_d;
            status_q   <= status_d;
            result_q   <= result_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cs         = cs_q;
    assign we         = we_q;
    assign address    = addr_q;
    assign write_data = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign status_out = status_q;
    assign result     = result_q;
endmodule

// File: tb/tb_chacha20_poly1305_bus_master.sv
// Bench for chacha20_poly1305_bus_master: two instances (gap 2 / limit 1024 and gap 0 / limit 4)
// driven from a vector table, checked against a transaction-list model and a bus responder.
module tb_chacha20_poly1305_bus_master;
    logic clk;
    logic reset;
    logic         start_r [2];
    logic [255:0] key_r   [2];
    logic [95:0]  nonce_r [2];
    logic [63:0]  data_r  [2];
    logic [31:0]  rd_r    [2];
    logic         cs_w [2], we_w [2], busy_w [2], done_w [2], err_w [2];
    logic [7:0]   addr_w [2];
    logic [31:0]  wd_w [2], st_w [2];
    logic [63:0]  res_w [2];

    typedef struct {
        int          u;
        int          rel;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } log_t;

    typedef struct {
        int           unit;
        int           zero;
        logic [255:0] key;
        logic [95:0]  nonce;
        logic [63:0]  data;
        logic [31:0]  stat;
        int           exp_done;
        bit           exp_err;
        bit           pulse;
    } vec_t;

    log_t log_q[$];
    log_t exp_q[$];
    int   cyc = 0;
    int   t0 [2] = '{0, 0};
    int   pc [2] = '{0, 0};
    int   pbase [2] = '{0, 0};
    int   zero_r [2] = '{0, 0};
    logic [31:0] st_rdy_r [2], st_wait_r [2], res0_r [2], res1_r [2];
    logic [63:0] prev_res [2];
    int   n_chk = 0;
    int   n_pass = 0;
    vec_t tbl [10];

    chacha20_poly1305_bus_master #(.POLL_LIMIT(1024), .INIT_GAP(8'd2)) dut0 (
        .clk(clk), .reset(reset), .start(start_r[0]), .key(key_r[0]), .nonce(nonce_r[0]),
        .data_in(data_r[0]), .busy(busy_w[0]), .done(done_w[0]), .error(err_w[0]),
        .status_out(st_w[0]), .result(res_w[0]), .cs(cs_w[0]), .we(we_w[0]),
        .address(addr_w[0]), .write_data(wd_w[0]), .read_data(rd_r[0]));

    chacha20_poly1305_bus_master #(.POLL_LIMIT(4), .INIT_GAP(8'd0)) dut1 (
        .clk(clk), .reset(reset), .start(start_r[1]), .key(key_r[1]), .nonce(nonce_r[1]),
        .data_in(data_r[1]), .busy(busy_w[1]), .done(done_w[1]), .error(err_w[1]),
        .status_out(st_w[1]), .result(res_w[1]), .cs(cs_w[1]), .we(we_w[1]),
        .address(addr_w[1]), .write_data(wd_w[1]), .read_data(rd_r[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: logs every access and answers reads one cycle later.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (cs_w[u]) begin
                log_q.push_back('{u, cyc - t0[u] + 1, we_w[u], addr_w[u], we_w[u] ? wd_w[u] : 32'h0});
                if (!we_w[u]) begin
                    if (addr_w[u] == 8'h09) begin
                        pc[u] <= pc[u] + 1;
                        rd_r[u] <= (pc[u] + 1 - pbase[u] > zero_r[u]) ? st_rdy_r[u] : st_wait_r[u];
                    end else if (addr_w[u] == 8'h40) begin
                        rd_r[u] <= res0_r[u];
                    end else if (addr_w[u] == 8'h41) begin
                        rd_r[u] <= res1_r[u];
                    end else begin
                        rd_r[u] <= 32'hdead_beef;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int lim(input int u);
        return (u == 0) ? 1024 : 4;
    endfunction

    function automatic logic [63:0] pk(input log_t e);
        return {7'd0, e.rel[15:0], e.we, e.addr, e.data};
    endfunction

    // Expected bus transaction list built straight from the operation sequence; returns done cycle.
    function automatic int build_exp(input int u, input logic [255:0] k, input logic [95:0] n,
                                     input logic [63:0] d, input int zero);
        int c, g, np;
        bit to;
        exp_q.delete();
        g  = (u == 0) ? 2 : 0;
        to = (zero >= lim(u));
        np = to ? lim(u) : zero + 1;
        c  = 1;
        for (int i = 0; i < 8; i++) begin exp_q.push_back('{u, c, 1'b1, 8'h10 + 8'(i), k[32*i +: 32]}); c++; end
        for (int i = 0; i < 3; i++) begin exp_q.push_back('{u, c, 1'b1, 8'h20 + 8'(i), n[32*i +: 32]}); c++; end
        for (int i = 0; i < 2; i++) begin exp_q.push_back('{u, c, 1'b1, 8'h30 + 8'(i), d[32*i +: 32]}); c++; end
        exp_q.push_back('{u, c, 1'b1, 8'h08, 32'h1}); c = c + 1 + g;
        exp_q.push_back('{u, c, 1'b1, 8'h08, 32'h2}); c++;
        for (int p = 0; p < np; p++) begin exp_q.push_back('{u, c, 1'b0, 8'h09, 32'h0}); c += 2; end
        if (!to) begin
            exp_q.push_back('{u, c, 1'b1, 8'h08, 32'h4}); c++;
            exp_q.push_back('{u, c, 1'b0, 8'h40, 32'h0}); c += 2;
            exp_q.push_back('{u, c, 1'b0, 8'h41, 32'h0}); c += 2;
        end
        return c;
    endfunction

    task automatic run_vec(input vec_t v);
        int u, r, dc, lb, mdone;
        bit got, terr;
        logic [63:0] eres;
        logic [31:0] estat;
        log_t act[$];
        u     = v.unit;
        terr  = (v.zero >= lim(u));
        mdone = build_exp(u, v.key, v.nonce, v.data, v.zero);
        @(negedge clk);
        key_r[u] = v.key; nonce_r[u] = v.nonce; data_r[u] = v.data;
        zero_r[u] = v.zero; st_rdy_r[u] = v.stat; st_wait_r[u] = $urandom() & 32'hffff_fffe;
        res0_r[u] = $urandom(); res1_r[u] = $urandom();
        pbase[u] = pc[u]; lb = log_q.size();
        start_r[u] = 1'b1;
        @(posedge clk); #1;
        t0[u] = cyc; start_r[u] = 1'b0;
        got = 1'b0; dc = 0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            r = cyc - t0[u] + 1;
            if (r == 1) begin chk("busy_run", busy_w[u], 1); chk("err_clr", err_w[u], 0); end
            if (v.pulse && (r == 4 || r == 19)) begin
                start_r[u] = 1'b1; key_r[u] = ~v.key; nonce_r[u] = ~v.nonce; data_r[u] = ~v.data;
            end else begin
                start_r[u] = 1'b0;
            end
            if (done_w[u]) begin got = 1'b1; dc = r; end
        end
        if (!got) chk("done_seen", 0, 1);
        estat = terr ? st_wait_r[u] : v.stat;
        eres  = terr ? prev_res[u] : {res1_r[u], res0_r[u]};
        prev_res[u] = eres;
        chk("done_cycle", dc, v.exp_done);
        chk("model_done_cycle", dc, mdone);
        chk("error", err_w[u], v.exp_err);
        chk("busy_at_done", busy_w[u], 0);
        chk("status_out", st_w[u], estat);
        chk("result", res_w[u], eres);
        @(negedge clk); #1;
        chk("done_pulse_len", done_w[u], 0);
        chk("error_held", err_w[u], v.exp_err);
        for (int i = lb; i < log_q.size(); i++)
            if (log_q[i].u == u) act.push_back(log_q[i]);
        chk("n_trans", act.size(), exp_q.size());
        for (int i = 0; i < act.size() && i < exp_q.size(); i++)
            chk($sformatf("trans%0d_u%0d", i, u), pk(act[i]), pk(exp_q[i]));
    endtask

    task automatic chk_zero(input int u);
        chk("rst_cs", cs_w[u], 0);        chk("rst_we", we_w[u], 0);
        chk("rst_addr", addr_w[u], 0);    chk("rst_wdata", wd_w[u], 0);
        chk("rst_busy", busy_w[u], 0);    chk("rst_done", done_w[u], 0);
        chk("rst_error", err_w[u], 0);    chk("rst_status", st_w[u], 0);
        chk("rst_result", res_w[u], 0);
    endtask

    initial begin
        logic [255:0] nkey;
        logic [95:0]  nnon;
        logic [63:0]  ndat;
        int lb, r;
        nkey = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_deadbeef_feedface;
        nnon = {32'h03030303, 32'h02020202, 32'h01010101};
        ndat = {32'hbbbbbbbb, 32'haaaaaaaa};
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_r[u] = 1'b0; key_r[u] = '0; nonce_r[u] = '0; data_r[u] = '0;
            st_rdy_r[u] = 32'h1; st_wait_r[u] = 32'h0; res0_r[u] = '0; res1_r[u] = '0;
            prev_res[u] = 64'h0;
        end
        #2;
        chk_zero(0);
        chk_zero(1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        tbl[0] = '{0, 0,  nkey, nnon, ndat, 32'h1, 25, 1'b0, 1'b0};
        tbl[1] = '{0, 2,  nkey, nnon, ndat, 32'h1, 29, 1'b0, 1'b0};
        tbl[2] = '{1, 1,  ~nkey, ~nnon, ~ndat, 32'h5, 25, 1'b0, 1'b0};
        tbl[3] = '{1, 99, nkey, nnon, ndat, 32'h1, 24, 1'b1, 1'b0};
        tbl[4] = '{0, 0,  {8{$urandom()}}, {3{$urandom()}}, {2{$urandom()}}, 32'h1, 25, 1'b0, 1'b1};
        for (int i = 5; i < 10; i++) begin
            tbl[i].unit  = int'($urandom_range(0, 1));
            tbl[i].zero  = int'($urandom_range(0, 5));
            tbl[i].key   = {$urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom()};
            tbl[i].nonce = {$urandom(), $urandom(), $urandom()};
            tbl[i].data  = {$urandom(), $urandom()};
            tbl[i].stat  = $urandom() | 32'h1;
            tbl[i].exp_done = build_exp(tbl[i].unit, tbl[i].key, tbl[i].nonce, tbl[i].data, tbl[i].zero);
            tbl[i].exp_err  = (tbl[i].zero >= lim(tbl[i].unit));
            tbl[i].pulse    = 1'b0;
        end
        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Reset in the middle of the nonce writes abandons the run.
        @(negedge clk);
        key_r[0] = nkey; nonce_r[0] = nnon; data_r[0] = ndat; start_r[0] = 1'b1;
        @(posedge clk); #1;
        t0[0] = cyc; start_r[0] = 1'b0;
        r = 0;
        for (int n = 0; n < 50 && r < 10; n++) begin
            @(negedge clk);
            r = cyc - t0[0] + 1;
        end
        chk("mid_cs_before_reset", cs_w[0], 1);
        #2 reset = 1'b1;
        #1;
        chk_zero(0);
        chk("rst_u1_status", st_w[1], 0);
        chk("rst_u1_result", res_w[1], 0);
        lb = log_q.size();
        @(negedge clk);
        reset = 1'b0;
        prev_res[0] = 64'h0; prev_res[1] = 64'h0;
        repeat (6) @(negedge clk);
        chk("no_access_after_reset", log_q.size(), lb);
        chk("idle_after_reset", busy_w[0], 0);
        run_vec(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
